seed_sequencer: RTL and testbench
=================================

SEED_SEQUENCER -- requirements
Module: seed_sequencer

Interface
REQ-001 Parameter WIDTH, default 64: width of seed and state register, min 2.
REQ-002 Parameter DIV_W, default 8: width of run-mode period counter.
REQ-003 Parameter TAPS, default 64'hD800_0000_0000_0000: Galois LFSR feedback mask, WIDTH bits.
REQ-004 Ports, clock and reset first; reset is asynchronous, active-high, and the clock is clk:
- clk  in  1  clock
- reset  in  1  asynchronous active-high reset
- seed  in  WIDTH  value loaded by load
- load  in  1  level; load seed into state
- step  in  1  switch; one advance per rising edge
- run  in  1  level switch; free-running advance while high
- mode  in  2  00 rotate-left, 01 rotate-right, 10 LFSR, 11 hold
- period  in  DIV_W  run mode advances every period+1 cycles
- shift_seed  out  WIDTH  current state register
- update  out  1  one-cycle pulse, high in the cycle shift_seed shows a new value
- running  out  1  high while FSM is in RUN
- is_zero  out  1  registered flag, shift_seed == 0

Function
REQ-005 The FSM SHALL have two states: IDLE and RUN.
REQ-006 IDLE -> RUN when run=1 and load=0. The period counter is loaded with period in the same edge.
REQ-007 RUN -> IDLE when run=0. The counter is cleared and no advance occurs on that edge.
REQ-008 Priority, highest first: load > step edge > run-timer advance. At most one state update per cycle.
REQ-009 Load (either state): shift_seed <= seed and update pulses.
- In RUN, a load also reloads the counter with period.
- The state is unchanged by a load.
REQ-010 Step: a registered copy of step detects the rising edge (step=1, previous=0). In IDLE, one advance per edge. Step edges are ignored in RUN.
REQ-011 RUN timer:
- When the counter is 0, advance and reload with period.
- Otherwise decrement.
- period=0 gives an advance every cycle.
- period is sampled only at reload.
REQ-012 Advance function s -> next, selected by mode at the advancing edge:
- rotate-left: {s[W-2:0], s[W-1]}
- rotate-right: {s[0], s[W-1:1]}
- LFSR: (s>>1) ^ (s[0] ? TAPS : 0)
- hold: s unchanged
REQ-013 LFSR lockup: when mode=LFSR and s==0, an advance SHALL produce 1.
REQ-014 In hold mode, an advance SHALL NOT pulse update. The RUN timer still counts and reloads.
REQ-015 A mode change mid-RUN SHALL take effect at the next advance without resetting the counter.
REQ-016 update, shift_seed and is_zero SHALL be registered with zero combinational input-to-output paths. Latency from the qualifying input edge to the new shift_seed SHALL be 1 cycle.
REQ-017 The counter SHALL wrap only through reload and never underflow.

Reset
REQ-018 On reset:
- shift_seed=0, is_zero=1, update=0, running=0
- state=IDLE, counter=0, step history=0
REQ-019 Reset asserted mid-RUN SHALL abort immediately. Deassertion SHALL NOT count as a step edge, even if step=1.

Structure
REQ-020 Package seed_pkg SHALL hold the FSM state enum (IDLE, RUN) and the mode enum (ROT_L=0, ROT_R=1, LFSR=2, HOLD=3).
REQ-021 Sub-module seed_step_unit SHALL be the combinational advance function (WIDTH, TAPS; s, mode -> next), instantiated once.

Verification (WIDTH=8, TAPS=8'hB8)
REQ-022 Reset, then load=1 with seed=8'h81 for one cycle -> shift_seed=8'h81, update=1 for exactly one cycle.
REQ-023 From 8'h81, mode=00, step toggled 0->1 and held high for 5 cycles -> shift_seed=8'h03 with a single update. Repeat with mode=01 -> 8'hC0.
REQ-024 mode=10, load 8'h01, two step edges -> 8'hB8 then 8'h5C. Load 8'h00 and step -> 8'h01, is_zero goes 1 then 0.
REQ-025 mode=00, load 8'h01, run=1 with period=2 -> update every 3 cycles, values 02, 04, 08. run=0 -> running=0 next cycle with no further updates.
REQ-026 In RUN, load and timer expiry coincide -> seed loaded, counter reloaded. Assert reset mid-RUN -> all outputs at reset values immediately.

Source files
------------

// File: rtl/seed_pkg.sv
// Shared types for the seed sequencer: FSM state and advance-mode encodings.
package seed_pkg;

   typedef enum logic {
      IDLE = 1'b0,
      RUN  = 1'b1
   } state_e;

   typedef enum logic [1:0] {
      ROT_L = 2'd0,
      ROT_R = 2'd1,
      LFSR  = 2'd2,
      HOLD  = 2'd3
   } mode_e;

endpackage

// File: rtl/seed_sequencer_if.sv
// Control/status bundle of the seed sequencer.
//   master: drives seed, load, step, run, mode, period; observes status
//   slave : the sequencer; drives shift_seed, update, running, is_zero
interface seed_sequencer_if
   import seed_pkg::*;
#(
   parameter int unsigned WIDTH = 64,
   parameter int unsigned DIV_W = 8
);

   logic [WIDTH-1:0] seed;
   logic             load;
   logic             step;
   logic             run;
   mode_e            mode;
   logic [DIV_W-1:0] period;
   logic [WIDTH-1:0] shift_seed;
   logic             update;
   logic             running;
   logic             is_zero;

   modport master (
      output seed, load, step, run, mode, period,
      input  shift_seed, update, running, is_zero
   );

   modport slave (
      input  seed, load, step, run, mode, period,
      output shift_seed, update, running, is_zero
   );

endinterface

// File: rtl/seed_step_unit.sv
// Combinational advance function of the seed register.
//   s      : current state
//   mode   : ROT_L / ROT_R / LFSR / HOLD
//   next_c : advanced state
module seed_step_unit
   import seed_pkg::*;
#(
   parameter int unsigned        WIDTH = 64,
   parameter logic [WIDTH-1:0]   TAPS  = WIDTH'(64'hD800_0000_0000_0000)
) (
   input  logic [WIDTH-1:0] s,
   input  mode_e            mode,
   output logic [WIDTH-1:0] next_c
);

   always_comb begin
      next_c = s;
      case (mode)
         ROT_L: next_c = {s[WIDTH-2:0], s[WIDTH-1]};
         ROT_R: next_c = {s[0], s[WIDTH-1:1]};
         LFSR: begin
            // The all-zero state is an LFSR lockup; escape it to 1.
            if (s == '0) next_c = WIDTH'(1);
            else         next_c = (s >> 1) ^ (s[0] ? TAPS : '0);
         end
         HOLD:    next_c = s;
         default: next_c = s;
      endcase
   end

endmodule

// File: rtl/seed_sequencer.sv
// Seed register with load, single-step and free-running timed advance.
//   clk, reset : clock, asynchronous active-high reset
//   bus        : seed_sequencer_if.slave (seed/load/step/run/mode/period in;
//                shift_seed/update/running/is_zero out, all registered)
module seed_sequencer
   import seed_pkg::*;
#(
   parameter int unsigned      WIDTH = 64,
   parameter int unsigned      DIV_W = 8,
   parameter logic [WIDTH-1:0] TAPS  = WIDTH'(64'hD800_0000_0000_0000)
) (
   input  logic             clk,
   input  logic             reset,
   seed_sequencer_if.slave  bus
);

   state_e           state_q, state_d;
   logic [DIV_W-1:0] cnt_q, cnt_d;
   logic [WIDTH-1:0] shift_q, shift_d;
   logic [WIDTH-1:0] adv_c;
   logic             step_q;
   logic             armed_q;
   logic             update_q, update_d;
   logic             running_q;
   logic             is_zero_q;
   logic             do_load, do_adv;
   logic             step_edge;

   // armed_q masks the first cycle after reset so a step held high across
   // reset release is not seen as an edge.
   assign step_edge = bus.step & ~step_q & armed_q;

   seed_step_unit #(
      .WIDTH (WIDTH),
      .TAPS  (TAPS)
   ) u_step (
      .s      (shift_q),
      .mode   (bus.mode),
      .next_c (adv_c)
   );

   // State and output registers.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q   <= IDLE;
         cnt_q     <= '0;
         shift_q   <= '0;
         step_q    <= 1'b0;
         armed_q   <= 1'b0;
         update_q  <= 1'b0;
         running_q <= 1'b0;
         is_zero_q <= 1'b1;
      end else begin
         state_q   <= state_d;
         cnt_q     <= cnt_d;
         shift_q   <= shift_d;
         step_q    <= bus.step;
         armed_q   <= 1'b1;
         update_q  <= update_d;
         running_q <= (state_d == RUN);
         is_zero_q <= (shift_d == '0);
      end
   end

   // Next state, period timer and update selection (load > step > timer).
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      do_load = 1'b0;
      do_adv  = 1'b0;
      case (state_q)
         IDLE: begin
            if (bus.load)      do_load = 1'b1;
            else if (step_edge) do_adv = 1'b1;
            if (bus.run && !bus.load) begin
               state_d = RUN;
               cnt_d   = bus.period;
            end
         end
         RUN: begin
            if (!bus.run) begin
               state_d = IDLE;
               cnt_d   = '0;
               do_load = bus.load;
            end else if (bus.load) begin
               do_load = 1'b1;
               cnt_d   = bus.period;
            end else if (cnt_q == '0) begin
               do_adv = 1'b1;
               cnt_d  = bus.period;
            end else begin
               cnt_d = cnt_q - DIV_W'(1);
            end
         end
         default: begin
            state_d = IDLE;
            cnt_d   = '0;
         end
      endcase

      if (do_load)     shift_d = bus.seed;
      else if (do_adv) shift_d = adv_c;
      else             shift_d = shift_q;

      // A HOLD advance leaves the value unchanged, so it is not announced.
      update_d = do_load | (do_adv & (bus.mode != HOLD));
   end

   assign bus.shift_seed = shift_q;
   assign bus.update     = update_q;
   assign bus.running    = running_q;
   assign bus.is_zero    = is_zero_q;

endmodule

// File: tb/tb_seed_sequencer.sv
// Self-checking bench for seed_sequencer (WIDTH=8, TAPS=8'hB8): directed
// vector table, hand sequences for RUN corner cases and reset, then random
// stimulus against a behavioural model.
module tb_seed_sequencer;
   import seed_pkg::*;

   logic clk = 1'b0;
   logic reset;
   always #5 clk = ~clk;

   seed_sequencer_if #(.WIDTH(8), .DIV_W(8)) bus ();

   seed_sequencer #(
      .WIDTH (8),
      .DIV_W (8),
      .TAPS  (8'hB8)
   ) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   int n_checks = 0;
   int n_errors = 0;

   // Behavioural model state
   int m_shift;
   int m_cnt;
   bit m_run;
   bit m_upd;
   bit m_prev;
   bit m_armed;

   typedef struct {
      bit load;
      bit step;
      bit run;
      int mode;
      int period;
      int seed;
      int e_shift;
      bit e_upd;
      bit e_run;
      bit e_zero;
   } vec_t;

   vec_t tv[$];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   function automatic int advance(input int s, input int md);
      case (md)
         0:       return ((s << 1) | (s >> 7)) & 255;
         1:       return ((s >> 1) | ((s & 1) << 7)) & 255;
         2:       return (s == 0) ? 1 : ((s >> 1) ^ (((s & 1) != 0) ? 'hB8 : 0));
         default: return s;
      endcase
   endfunction

   task automatic model_reset();
      m_shift = 0; m_cnt = 0; m_run = 0; m_upd = 0; m_prev = 0; m_armed = 0;
   endtask

   // Apply one clock edge of the spec's rules to the model, using current inputs.
   task automatic model_edge();
      bit edge_seen;
      int md;
      if (reset) begin
         model_reset();
      end else begin
         md = int'(bus.mode);
         edge_seen = m_armed && bus.step && !m_prev;
         m_upd = 0;
         if (m_run) begin
            if (!bus.run) begin
               m_run = 0;
               m_cnt = 0;
               if (bus.load) begin m_shift = int'(bus.seed); m_upd = 1; end
            end else if (bus.load) begin
               m_shift = int'(bus.seed); m_upd = 1; m_cnt = int'(bus.period);
            end else if (m_cnt == 0) begin
               m_shift = advance(m_shift, md); m_upd = (md != 3); m_cnt = int'(bus.period);
            end else begin
               m_cnt = m_cnt - 1;
            end
         end else begin
            if (bus.load) begin
               m_shift = int'(bus.seed); m_upd = 1;
            end else if (edge_seen) begin
               m_shift = advance(m_shift, md); m_upd = (md != 3);
            end
            if (bus.run && !bus.load) begin
               m_run = 1; m_cnt = int'(bus.period);
            end
         end
         m_prev  = bus.step;
         m_armed = 1;
      end
   endtask

   task automatic compare_model(input string tag);
      check({tag, " shift_seed"}, 32'(bus.shift_seed), 32'(m_shift));
      check({tag, " update"},     32'(bus.update),     32'(m_upd));
      check({tag, " running"},    32'(bus.running),    32'(m_run));
      check({tag, " is_zero"},    32'(bus.is_zero),    32'(m_shift == 0));
   endtask

   task automatic tick(input string tag);
      model_edge();
      @(posedge clk);
      #1;
      compare_model(tag);
   endtask

   task automatic drive(input bit ld, input bit st, input bit rn, input int md,
                        input int per, input int sd);
      bus.load   = ld;
      bus.step   = st;
      bus.run    = rn;
      bus.mode   = mode_e'(md[1:0]);
      bus.period = 8'(per);
      bus.seed   = 8'(sd);
   endtask

   task automatic expect_out(input string tag, input int sh, input bit up,
                             input bit rn, input bit z);
      check({tag, " shift_seed"}, 32'(bus.shift_seed), 32'(sh));
      check({tag, " update"},     32'(bus.update),     32'(up));
      check({tag, " running"},    32'(bus.running),    32'(rn));
      check({tag, " is_zero"},    32'(bus.is_zero),    32'(z));
   endtask

   function automatic void add(input bit ld, input bit st, input bit rn, input int md,
                               input int per, input int sd, input int esh,
                               input bit eup, input bit ern, input bit ez);
      vec_t v;
      v.load = ld; v.step = st; v.run = rn; v.mode = md; v.period = per; v.seed = sd;
      v.e_shift = esh; v.e_upd = eup; v.e_run = ern; v.e_zero = ez;
      tv.push_back(v);
   endfunction

   initial begin
      // Reset with step held high; release must not count as a step edge.
      reset = 1'b1;
      drive(0, 1, 0, 0, 0, 0);
      model_reset();
      repeat (3) @(posedge clk);
      #1;
      expect_out("reset", 0, 0, 0, 1);
      reset = 1'b0;

      // Directed vectors
      add(0,1,0,0,0,8'h00, 8'h00,0,0,1);
      add(1,0,0,0,0,8'h81, 8'h81,1,0,0);
      add(0,0,0,0,0,8'h00, 8'h81,0,0,0);
      add(0,1,0,0,0,8'h00, 8'h03,1,0,0);
      for (int k = 0; k < 4; k++) add(0,1,0,0,0,8'h00, 8'h03,0,0,0);
      add(1,0,0,0,0,8'h81, 8'h81,1,0,0);
      add(0,1,0,1,0,8'h00, 8'hC0,1,0,0);
      add(0,1,0,1,0,8'h00, 8'hC0,0,0,0);
      add(1,0,0,2,0,8'h01, 8'h01,1,0,0);
      add(0,1,0,2,0,8'h00, 8'hB8,1,0,0);
      add(0,0,0,2,0,8'h00, 8'hB8,0,0,0);
      add(0,1,0,2,0,8'h00, 8'h5C,1,0,0);
      add(1,0,0,2,0,8'h00, 8'h00,1,0,1);
      add(0,1,0,2,0,8'h00, 8'h01,1,0,0);
      add(1,0,0,0,0,8'h01, 8'h01,1,0,0);
      add(0,0,1,0,2,8'h00, 8'h01,0,1,0);
      add(0,0,1,0,2,8'h00, 8'h01,0,1,0);
      add(0,0,1,0,2,8'h00, 8'h01,0,1,0);
      add(0,0,1,0,2,8'h00, 8'h02,1,1,0);
      add(0,0,1,0,2,8'h00, 8'h02,0,1,0);
      add(0,0,1,0,2,8'h00, 8'h02,0,1,0);
      add(0,0,1,0,2,8'h00, 8'h04,1,1,0);
      add(0,0,1,0,2,8'h00, 8'h04,0,1,0);
      add(0,0,1,0,2,8'h00, 8'h04,0,1,0);
      add(0,0,1,0,2,8'h00, 8'h08,1,1,0);
      add(0,0,0,0,2,8'h00, 8'h08,0,0,0);
      add(0,0,0,0,2,8'h00, 8'h08,0,0,0);

      foreach (tv[i]) begin
         drive(tv[i].load, tv[i].step, tv[i].run, tv[i].mode, tv[i].period, tv[i].seed);
         tick($sformatf("vec%0d model", i));
         expect_out($sformatf("vec%0d", i), tv[i].e_shift, tv[i].e_upd, tv[i].e_run, tv[i].e_zero);
      end

      // Load coinciding with timer expiry in RUN
      drive(1, 0, 0, 0, 0, 8'h01); tick("seqA load");
      drive(0, 0, 1, 0, 1, 8'h00); tick("seqA enter");
      tick("seqA count");
      drive(1, 0, 1, 0, 1, 8'h55); tick("seqA collide");
      expect_out("seqA collide", 8'h55, 1, 1, 0);
      drive(0, 0, 1, 0, 1, 8'h00); tick("seqA reload");
      expect_out("seqA reload", 8'h55, 0, 1, 0);
      tick("seqA adv");
      expect_out("seqA adv", 8'hAA, 1, 1, 0);

      // HOLD in RUN: timer keeps cycling, no updates, steps ignored
      for (int k = 0; k < 4; k++) begin
         drive(0, k[0], 1, 3, 1, 8'h00);
         tick($sformatf("seqB hold%0d", k));
         expect_out($sformatf("seqB hold%0d", k), 8'hAA, 0, 1, 0);
      end
      // Mode change mid-RUN applies at the next advance, counter undisturbed
      drive(0, 0, 1, 1, 1, 8'h00); tick("seqB wait");
      expect_out("seqB wait", 8'hAA, 0, 1, 0);
      tick("seqB rotr");
      expect_out("seqB rotr", 8'h55, 1, 1, 0);

      // Reset mid-RUN acts without a clock edge
      drive(0, 1, 1, 1, 1, 8'h00);
      @(negedge clk);
      reset = 1'b1;
      bus.run = 1'b0;
      #1;
      expect_out("async reset", 0, 0, 0, 1);
      model_reset();
      @(posedge clk);
      #1;
      reset = 1'b0;
      tick("post reset step high");
      expect_out("post reset step high", 0, 0, 0, 1);

      // Random stimulus against the model
      begin
         bit rn;
         rn = 0;
         for (int i = 0; i < 800; i++) begin
            int sd;
            if ($urandom_range(7) == 0) rn = ~rn;
            sd = ($urandom_range(7) == 0) ? 0 : int'($urandom_range(255));
            drive($urandom_range(9) == 0, 1'($urandom_range(1)), rn,
                  int'($urandom_range(3)), int'($urandom_range(3)), sd);
            if ($urandom_range(149) == 0) reset = 1'b1;
            tick($sformatf("rand%0d", i));
            reset = 1'b0;
         end
      end

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule
